// File: rtl/bmc_pipe.sv
// bmc_pipe: 3-stage soft-decision branch metric unit (distances, raw metrics + min, normalised metrics).
// Define BMC_PUNCTURE_EN to add the in_erase port for punctured-code erasures.
module bmc_pipe #(
  parameter int R  = 2,
  parameter int SW = 3,
  parameter int CW = 12,
  localparam int BW = SW + $clog2(R),
  localparam int H  = 1 << R
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [R*SW-1:0] in_sym,
  input  logic            in_last,
`ifdef BMC_PUNCTURE_EN
  input  logic [R-1:0]    in_erase,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [H*BW-1:0] out_bm,
  output logic [R-1:0]    out_min_idx,
  output logic            out_last,
  output logic [CW-1:0]   out_cnt
);

  function automatic logic [SW-1:0] flip(input logic [SW-1:0] s);
    return ~s;
  endfunction

  function automatic logic [BW-1:0] widen(input logic [SW-1:0] d);
    return {{(BW-SW){1'b0}}, d};
  endfunction

  function automatic logic [BW-1:0] norm(input logic [BW-1:0] m, input logic [BW-1:0] mn);
    return m - mn;
  endfunction

  logic [SW-1:0] d0_in [R];
  logic [SW-1:0] d1_in [R];
  logic [SW-1:0] d0_p0 [R];
  logic [SW-1:0] d1_p0 [R];
  logic          last_p0;
  logic [CW-1:0] cnt_p0;
  logic          vld_p0;

  logic [BW-1:0] m_c [H];
  logic [BW-1:0] min_c;
  logic [R-1:0]  idx_c;
  logic [BW-1:0] m_p1 [H];
  logic [BW-1:0] min_p1;
  logic [R-1:0]  idx_p1;
  logic          last_p1;
  logic [CW-1:0] cnt_p1;
  logic          vld_p1;

  logic [H*BW-1:0] bm_c;
  logic [CW-1:0]   cnt;
  logic            adv_p0, adv_p1, adv_p2;
  logic            ld_p1, ld_p2;
  logic            accept;

  // Ready chain runs back from the output port, combinationally
  assign adv_p2    = out_valid & out_ready;
  assign ld_p2     = ~out_valid | adv_p2;
  assign adv_p1    = vld_p1 & ld_p2;
  assign ld_p1     = ~vld_p1 | adv_p1;
  assign adv_p0    = vld_p0 & ld_p1;
  assign in_ready  = ~vld_p0 | adv_p0;
  assign accept    = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < R; i++) begin
      d0_in[i] = in_sym[i*SW +: SW];
      d1_in[i] = flip(in_sym[i*SW +: SW]);
`ifdef BMC_PUNCTURE_EN
      if (in_erase[i]) begin
        d0_in[i] = '0;
        d1_in[i] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (in_ready) vld_p0 <= in_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) out_valid <= vld_p1;
      if (accept) cnt <= in_last ? '0 : cnt + CW'(1);
    end
  end

  // Stage p0: per-symbol distances to '0' and '1'
  always_ff @(posedge clk) begin
    if (accept) begin
      d0_p0   <= d0_in;
      d1_p0   <= d1_in;
      last_p0 <= in_last;
      cnt_p0  <= cnt;
    end
  end

  always_comb begin
    for (int h = 0; h < H; h++) begin
      m_c[h] = '0;
      for (int i = 0; i < R; i++)
        m_c[h] = m_c[h] + widen(h[i] ? d1_p0[i] : d0_p0[i]);
    end
    min_c = m_c[0];
    idx_c = '0;
    for (int h = 1; h < H; h++) begin
      if (m_c[h] < min_c) begin
        min_c = m_c[h];
        idx_c = h[R-1:0];
      end
    end
  end

  // Stage p1: raw hypothesis metrics and the first-occurring minimum
  always_ff @(posedge clk) begin
    if (adv_p0) begin
      m_p1    <= m_c;
      min_p1  <= min_c;
      idx_p1  <= idx_c;
      last_p1 <= last_p0;
      cnt_p1  <= cnt_p0;
    end
  end

  always_comb begin
    bm_c = '0;
    for (int h = 0; h < H; h++)
      bm_c[h*BW +: BW] = norm(m_p1[h], min_p1);
  end

  // Stage p2: normalised metrics presented on the output port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_bm      <= '0;
      out_min_idx <= '0;
      out_last    <= 1'b0;
      out_cnt     <= '0;
    end else if (adv_p1) begin
      out_bm      <= bm_c;
      out_min_idx <= idx_p1;
      out_last    <= last_p1;
      out_cnt     <= cnt_p1;
    end
  end

endmodule
